// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multicycle RV32I core: sequences IF/ID/EX/MEM/WB and
// drives every datapath enable and mux select, including alu_op for ALU control.
module multicycle_control_fsm #(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       alu_bcond,
  output logic       pc_write,
  output logic       pc_source,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mdr_write,
  output logic       alu_out_write,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       alu_funct7_en,
  output logic       is_ecall,
  output logic       illegal_op
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_ECALL  = 7'b1110011;

  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

  typedef enum logic [2:0] {
    S_IF, S_ID, S_EX, S_BR_EX, S_BR_TGT, S_MEM, S_WB
  } state_t;

  state_t     state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic       last;

  assign last = (cnt == WAIT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IF;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    cnt_nx        = '0;
    pc_write      = 1'b0;
    pc_source     = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mdr_write     = 1'b0;
    alu_out_write = 1'b0;
    reg_write     = 1'b0;
    wb_sel        = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    alu_funct7_en = 1'b0;
    is_ecall      = 1'b0;
    illegal_op    = 1'b0;

    unique case (state)
      S_IF: begin
        mem_read = 1'b1;
        if (last) begin
          ir_write = 1'b1;
          state_nx = S_ID;
        end else begin
          cnt_nx = cnt + 4'd1;
        end
      end

      // ALUOut <= PC+4 here so ECALL/illegal can redirect with the live sum
      S_ID: begin
        alu_src_b     = 2'b01;
        alu_out_write = 1'b1;
        case (opcode)
          OP_ECALL: begin
            is_ecall = 1'b1;
            pc_write = 1'b1;
            state_nx = S_IF;
          end
          OP_BRANCH: state_nx = S_BR_EX;
          OP_R, OP_I, OP_LOAD, OP_STORE, OP_JAL, OP_JALR: state_nx = S_EX;
          default: begin
            illegal_op = 1'b1;
            pc_write   = 1'b1;
            state_nx   = S_IF;
          end
        endcase
      end

      S_EX: begin
        state_nx = S_IF;
        case (opcode)
          OP_R: begin
            alu_src_a     = 1'b1;
            alu_op        = 2'b10;
            alu_funct7_en = 1'b1;
            alu_out_write = 1'b1;
            state_nx      = S_WB;
          end
          OP_I: begin
            alu_src_a     = 1'b1;
            alu_src_b     = 2'b10;
            alu_op        = 2'b10;
            alu_out_write = 1'b1;
            state_nx      = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_src_a     = 1'b1;
            alu_src_b     = 2'b10;
            alu_out_write = 1'b1;
            state_nx      = S_MEM;
          end
          // rd <= ALUOut (PC+4) while the live ALU sum is the jump target
          OP_JAL, OP_JALR: begin
            alu_src_a = (opcode == OP_JALR);
            alu_src_b = 2'b10;
            reg_write = 1'b1;
            pc_write  = 1'b1;
          end
          default: ;
        endcase
      end

      S_BR_EX: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        if (alu_bcond) begin
          state_nx = S_BR_TGT;
        end else begin
          pc_write  = 1'b1;
          pc_source = 1'b1;
          state_nx  = S_IF;
        end
      end

      S_BR_TGT: begin
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
        state_nx  = S_IF;
      end

      S_MEM: begin
        i_or_d    = 1'b1;
        alu_src_b = 2'b01;
        if (opcode == OP_STORE) begin
          if (last) begin
            mem_write = 1'b1;
            pc_write  = 1'b1;
            state_nx  = S_IF;
          end else begin
            cnt_nx = cnt + 4'd1;
          end
        end else begin
          mem_read = 1'b1;
          if (last) begin
            mdr_write = 1'b1;
            state_nx  = S_WB;
          end else begin
            cnt_nx = cnt + 4'd1;
          end
        end
      end

      S_WB: begin
        reg_write = 1'b1;
        wb_sel    = (opcode == OP_LOAD) ? 2'b01 : 2'b00;
        alu_src_b = 2'b01;
        pc_write  = 1'b1;
        state_nx  = S_IF;
      end

      default: state_nx = S_IF;
    endcase

    // reset silences everything regardless of where the instruction was
    if (reset) begin
      {pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write, mdr_write,
       alu_out_write, reg_write, wb_sel, alu_src_a, alu_src_b, alu_op,
       alu_funct7_en, is_ecall, illegal_op} = '0;
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench: two DUTs (MEM_WAIT 0 and 2) checked per cycle against an instruction-level
// expected-cycle list; the idle DUT is held in reset and must stay silent.
module tb_multicycle_control_fsm;

  localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011,
                         ST = 7'b0100011, BR = 7'b1100011, JAL = 7'b1101111,
                         JALR = 7'b1100111, EC = 7'b1110011;

  typedef struct packed {
    logic       pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write,
                mdr_write, alu_out_write, reg_write;
    logic [1:0] wb_sel;
    logic       alu_src_a;
    logic [1:0] alu_src_b, alu_op;
    logic       alu_funct7_en, is_ecall, illegal_op;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst0, rst2, alu_bcond;
  logic [6:0] opcode;
  exp_t       o0, o2, act, idle, exp_cur;
  logic       exp_vld = 1'b0;
  logic       sel = 1'b0;
  int         errors = 0, checks = 0;

  always #5 clk = ~clk;

  multicycle_control_fsm #(.MEM_WAIT(0)) dut0 (
    .clk(clk), .reset(rst0), .opcode(opcode), .alu_bcond(alu_bcond),
    .pc_write(o0.pc_write), .pc_source(o0.pc_source), .i_or_d(o0.i_or_d),
    .mem_read(o0.mem_read), .mem_write(o0.mem_write), .ir_write(o0.ir_write),
    .mdr_write(o0.mdr_write), .alu_out_write(o0.alu_out_write),
    .reg_write(o0.reg_write), .wb_sel(o0.wb_sel), .alu_src_a(o0.alu_src_a),
    .alu_src_b(o0.alu_src_b), .alu_op(o0.alu_op), .alu_funct7_en(o0.alu_funct7_en),
    .is_ecall(o0.is_ecall), .illegal_op(o0.illegal_op));

  multicycle_control_fsm #(.MEM_WAIT(2)) dut2 (
    .clk(clk), .reset(rst2), .opcode(opcode), .alu_bcond(alu_bcond),
    .pc_write(o2.pc_write), .pc_source(o2.pc_source), .i_or_d(o2.i_or_d),
    .mem_read(o2.mem_read), .mem_write(o2.mem_write), .ir_write(o2.ir_write),
    .mdr_write(o2.mdr_write), .alu_out_write(o2.alu_out_write),
    .reg_write(o2.reg_write), .wb_sel(o2.wb_sel), .alu_src_a(o2.alu_src_a),
    .alu_src_b(o2.alu_src_b), .alu_op(o2.alu_op), .alu_funct7_en(o2.alu_funct7_en),
    .is_ecall(o2.is_ecall), .illegal_op(o2.illegal_op));

  assign act  = sel ? o2 : o0;
  assign idle = sel ? o0 : o2;

  // Instruction-level model: the full list of per-cycle outputs for one instruction
  function automatic void build(input int mw, input logic [6:0] op, input logic bc,
                                output exp_t q[$]);
    exp_t e;
    q = {};
    for (int i = 0; i <= mw; i++) begin
      e = '0; e.mem_read = 1; e.ir_write = (i == mw); q.push_back(e);
    end
    e = '0; e.alu_src_b = 2'b01; e.alu_out_write = 1;
    if (op == EC) begin
      e.is_ecall = 1; e.pc_write = 1; q.push_back(e); return;
    end
    if (!(op inside {R, I, LD, ST, BR, JAL, JALR})) begin
      e.illegal_op = 1; e.pc_write = 1; q.push_back(e); return;
    end
    q.push_back(e);
    e = '0;
    if (op == BR) begin
      e.alu_src_a = 1; e.alu_op = 2'b01;
      if (!bc) begin e.pc_write = 1; e.pc_source = 1; q.push_back(e); return; end
      q.push_back(e);
      e = '0; e.alu_src_b = 2'b10; e.pc_write = 1; q.push_back(e); return;
    end
    if (op == JAL || op == JALR) begin
      e.alu_src_a = (op == JALR); e.alu_src_b = 2'b10; e.reg_write = 1; e.pc_write = 1;
      q.push_back(e); return;
    end
    e.alu_src_a = 1; e.alu_out_write = 1;
    e.alu_src_b = (op == R) ? 2'b00 : 2'b10;
    e.alu_op = (op == R || op == I) ? 2'b10 : 2'b00;
    e.alu_funct7_en = (op == R);
    q.push_back(e);
    if (op == LD || op == ST) begin
      for (int i = 0; i <= mw; i++) begin
        e = '0; e.i_or_d = 1; e.alu_src_b = 2'b01;
        if (op == LD) begin e.mem_read = 1; e.mdr_write = (i == mw); end
        else if (i == mw) begin e.mem_write = 1; e.pc_write = 1; end
        q.push_back(e);
      end
      if (op == ST) return;
    end
    e = '0; e.reg_write = 1; e.wb_sel = (op == LD) ? 2'b01 : 2'b00;
    e.alu_src_b = 2'b01; e.pc_write = 1;
    q.push_back(e);
  endfunction

  always @(negedge clk) begin
    if (exp_vld) begin
      checks++;
      if (act !== exp_cur) begin
        errors++;
        $display("FAIL cycle mw=%0d op=%b t=%0t: got %h want %h",
                 sel ? 2 : 0, opcode, $time, act, exp_cur);
      end
      checks++;
      if (idle !== '0) begin
        errors++;
        $display("FAIL idle_in_reset t=%0t: got %h want 0", $time, idle);
      end
    end
  end

  task automatic pin(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic model_len(input string name, input int mw, input logic [6:0] op,
                           input logic bc, input int want);
    exp_t q[$];
    build(mw, op, bc, q);
    pin(name, q.size(), want);
  endtask

  // Runs one instruction on DUT d; abort_at>=0 asserts reset in that cycle instead
  task automatic run(input bit d, input logic [6:0] op, input logic bc, input int abort_at);
    exp_t q[$];
    build(d ? 2 : 0, op, bc, q);
    sel = d; opcode = op; alu_bcond = bc;
    if (d) begin rst2 = 0; rst0 = 1; end else begin rst0 = 0; rst2 = 1; end
    foreach (q[i]) begin
      if (i == abort_at) begin
        if (d) rst2 = 1; else rst0 = 1;
        exp_cur = '0;
      end else begin
        exp_cur = q[i];
      end
      @(posedge clk); #1;
      if (i == abort_at) break;
    end
  endtask

  initial begin
    exp_t q[$];
    rst0 = 1; rst2 = 1; opcode = '0; alu_bcond = 0;
    exp_cur = '0; exp_vld = 1;
    repeat (3) @(posedge clk);
    #1;

    // pin the model with hand-counted cycle counts
    model_len("len_add_mw0", 0, R, 0, 4);
    model_len("len_lw_mw0", 0, LD, 0, 5);
    model_len("len_sw_mw0", 0, ST, 0, 4);
    model_len("len_beq_nt", 0, BR, 0, 3);
    model_len("len_beq_t", 0, BR, 1, 4);
    model_len("len_jal", 0, JAL, 0, 3);
    model_len("len_ecall", 0, EC, 0, 2);
    model_len("len_illegal", 0, 7'h7f, 0, 2);
    model_len("len_lw_mw2", 2, LD, 0, 9);
    build(0, I, 0, q);
    pin("addi_ex_funct7_en", int'(q[2].alu_funct7_en), 0);
    pin("addi_ex_alu_op", int'(q[2].alu_op), 2);
    build(0, LD, 0, q);
    pin("lw_wb_sel", int'(q[4].wb_sel), 1);

    run(0, R, 0, -1);
    run(0, I, 1, -1);
    run(0, LD, 0, -1);
    run(0, ST, 0, -1);
    run(0, BR, 0, -1);
    run(0, BR, 1, -1);
    run(0, JAL, 0, -1);
    run(0, JALR, 1, -1);
    run(0, EC, 0, -1);
    run(0, 7'h7f, 0, -1);
    run(1, LD, 0, -1);
    run(1, ST, 0, 6);       // reset in middle MEM cycle: no store issued
    run(1, R, 0, -1);
    run(1, BR, 1, -1);
    run(0, ST, 0, 3);       // reset on the store's only MEM cycle

    for (int n = 0; n < 300; n++) begin
      logic [6:0] op;
      logic [6:0] ops [8] = '{R, I, LD, ST, BR, JAL, JALR, EC};
      int ab;
      op = ($urandom_range(0, 4) == 0) ? 7'($urandom) : ops[$urandom_range(0, 7)];
      ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 8)) : -1;
      run(1'($urandom), op, 1'($urandom), ab);
    end

    exp_vld = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Main control state machine of the multicycle RV32I core. It steps each instruction through fetch/decode/execute/memory/writeback and drives all datapath enables and mux selects. It is the direct upstream feeder of the ALU control unit: it produces the 2-bit alu_op (00 add, 01 branch compare, 10 funct-decoded) and gates the funct7 bit that the ALU control unit sees.

Parameters:
MEM_WAIT, 0, extra wait cycles per memory access (IF and MEM states each last MEM_WAIT+1 cycles); legal range 0..15.

Ports:
clk  input  1  core clock, all state on rising edge
reset  input  1  synchronous, active-high
opcode  input  7  IR[6:0]; valid from ID onward
alu_bcond  input  1  branch-compare result from ALU, sampled in BR_EX
pc_write  output  1  PC load enable
pc_source  output  1  0 = live ALU result, 1 = ALUOut register
i_or_d  output  1  memory address select: 0 = PC, 1 = ALUOut
mem_read  output  1  memory read request
mem_write  output  1  memory write strobe
ir_write  output  1  IR load enable
mdr_write  output  1  MDR load enable
alu_out_write  output  1  ALUOut register load enable
reg_write  output  1  register-file write enable
wb_sel  output  2  00 = ALUOut, 01 = MDR, 10/11 reserved (never driven)
alu_src_a  output  1  0 = PC, 1 = rs1 latch A
alu_src_b  output  2  00 = rs2 latch B, 01 = constant 4, 10 = immediate
alu_op  output  2  to ALU control unit
alu_funct7_en  output  1  1 = pass IR[30] as funct7 to ALU control, 0 = force 0
is_ecall  output  1  one-cycle pulse on ECALL decode
illegal_op  output  1  one-cycle pulse on unknown opcode

Behaviour:
- Opcodes: R 0110011, I-arith 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, ECALL 1110011.
- States: IF, ID, EX, BR_EX, BR_TGT, MEM, WB. Moore outputs per state, plus opcode/bcond/counter qualifiers. Unlisted outputs are 0 and selects are 0.
- Reset: while reset=1, all enables and pulses are 0, all selects are 0, state<=IF, wait counter<=0. The first IF cycle follows the cycle in which reset is released. Reset asserted in any state, including mid-wait, aborts the instruction with no write issued.
- IF: mem_read=1, i_or_d=0. Wait counter counts 0..MEM_WAIT. ir_write=1 only on the final count, then go to ID and clear the counter.
- ID: alu_src_a=0, alu_src_b=01, alu_op=00, alu_out_write=1 (ALUOut<=PC+4).
  - ECALL: is_ecall=1, pc_write=1, pc_source=0, go to IF.
  - BRANCH: go to BR_EX.
  - Unknown opcode: illegal_op=1, pc_write=1, pc_source=0, go to IF.
  - All other opcodes: go to EX.
- EX, R: alu_src_a=1, src_b=00, alu_op=10, alu_funct7_en=1, alu_out_write=1, go to WB.
- EX, I-arith: src_a=1, src_b=10, alu_op=10, alu_funct7_en=0, alu_out_write=1, go to WB.
- EX, LOAD/STORE: src_a=1, src_b=10, alu_op=00, alu_out_write=1, go to MEM.
- EX, JAL (src_a=0) / JALR (src_a=1): src_b=10, alu_op=00, alu_out_write=0, reg_write=1, wb_sel=00 (rd<=PC+4), pc_write=1, pc_source=0, go to IF. Target LSB masking belongs to the datapath.
- BR_EX: src_a=1, src_b=00, alu_op=01, alu_out_write=0.
  - bcond=0: pc_write=1, pc_source=1 (PC+4), go to IF.
  - bcond=1: go to BR_TGT.
- BR_TGT: src_a=0, src_b=10, alu_op=00, pc_write=1, pc_source=0, go to IF.
- MEM: i_or_d=1. ALU drives PC+4 (src_a=0, src_b=01, alu_op=00). Counter as in IF.
  - LOAD: mem_read=1 on all cycles, mdr_write=1 on the final cycle, then go to WB.
  - STORE: mem_write=1 on the final cycle only, plus pc_write=1, pc_source=0, then go to IF.
- WB: reg_write=1, wb_sel=01 for LOAD else 00, ALU drives PC+4, pc_write=1, pc_source=0, go to IF.
- Invariants:
  - pc_write is 1 in exactly one cycle per instruction.
  - reg_write and mem_write are never both 1.
  - alu_op=11 is never driven.
  - The counter never exceeds MEM_WAIT.

Test Plan:
- MEM_WAIT=0, ADD x3,x1,x2 -> IF,ID,EX,WB (4 cycles); alu_op=10 and funct7_en=1 in EX; reg_write=1 and pc_write=1 only in WB.
- ADDI with imm bit30=1 -> funct7_en=0 in EX, alu_op=10; LW -> 5 cycles, mdr_write in MEM, wb_sel=01 in WB; SW -> 4 cycles, mem_write=1 exactly once, reg_write never 1.
- BEQ with bcond=0 -> 3 cycles, pc_source=1 in BR_EX; bcond=1 -> 4 cycles, pc_write only in BR_TGT with pc_source=0, src_b=10.
- JAL -> 3 cycles, EX has reg_write=1, wb_sel=00, pc_write=1, alu_src_a=0; JALR the same with alu_src_a=1; ECALL -> 2 cycles, is_ecall pulses once in ID.
- MEM_WAIT=2: LW -> 9 cycles, mem_read held 3 cycles in IF and 3 in MEM, ir_write/mdr_write single-cycle on the final count.
- Opcode 1111111 -> illegal_op pulse and pc_write in ID, back to IF. Reset asserted mid-MEM of a STORE -> mem_write never pulses; IF follows reset release.
